// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// pc_seq_pkg : shared types for the next-PC sequencer (FSM states, redirects)
// Revision   : 1.0
// ============================================================================
package pc_seq_pkg;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      RK_NONE  = 3'd0,
      RK_STALL = 3'd1,
      RK_RET   = 3'd2,
      RK_CALL  = 3'd3,
      RK_JMP   = 3'd4
   } redir_e;

   // Priority resolution; during a flush bubble every redirect is dropped.
   function automatic redir_e decode_redir(input logic stall, input logic flush,
                                           input logic ret, input logic call,
                                           input logic jmp);
      redir_e kind;
      if (stall)      kind = RK_STALL;
      else if (flush) kind = RK_NONE;
      else if (ret)   kind = RK_RET;
      else if (call)  kind = RK_CALL;
      else if (jmp)   kind = RK_JMP;
      else            kind = RK_NONE;
      return kind;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_ras_stack.sv
`default_nettype none
// ============================================================================
// ras_stack : DEPTH x W return-address LIFO, only the stack pointer is reset
// Revision  : 1.0
// ============================================================================
module ras_stack #(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               data_i,
   output logic [W-1:0]               top_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     sp_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   sp_q;
   logic [AW:0]   sp_d;
   logic [AW-1:0] top_idx;

   assign full_o  = (sp_q == (AW+1)'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign top_idx = sp_q[AW-1:0] - 1'b1;
   assign top_o   = mem_q[top_idx];
   assign sp_o    = sp_q;

   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o)
         sp_d = sp_q + 1'b1;
      else if (pop_i && !empty_o)
         sp_d = sp_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o)
         mem_q[sp_q[AW-1:0]] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : next-PC controller with return-address stack and fault halt
// Revision     : 1.0
// ============================================================================
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [W-1:0]           pc_in,
   input  logic                   stall,
   input  logic                   jmp,
   input  logic                   call,
   input  logic                   ret,
   input  logic [W-1:0]           jmp_addr,
   output logic                   cnt_st,
   output logic [W-1:0]           cnt_dat,
   output logic                   instr_valid,
   output logic                   halted,
   output logic                   err_ovf,
   output logic                   err_unf,
   output logic [$clog2(DEPTH):0] ras_depth
);

   state_e        state_q;
   state_e        state_d;
   redir_e        kind;
   logic          flush_q;
   logic          flush_d;
   logic          err_ovf_q;
   logic          err_unf_q;
   logic          fault_ovf;
   logic          fault_unf;
   logic          ras_push;
   logic          ras_pop;
   logic          ras_full;
   logic          ras_empty;
   logic [W-1:0]  ras_top;
   logic [W-1:0]  ret_addr;

   assign ret_addr = pc_in + W'(1);
   assign kind     = decode_redir(stall, flush_q, ret, call, jmp);

   ras_stack #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (ret_addr),
      .top_o   (ras_top),
      .full_o  (ras_full),
      .empty_o (ras_empty),
      .sp_o    (ras_depth)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         flush_q   <= 1'b0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flush_q   <= flush_d;
         err_ovf_q <= err_ovf_q | fault_ovf;
         err_unf_q <= err_unf_q | fault_unf;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == ST_RUN && (fault_ovf || fault_unf))
         state_d = ST_HALT;
   end

   always_comb begin
      cnt_st      = 1'b0;
      cnt_dat     = '0;
      instr_valid = 1'b0;
      ras_push    = 1'b0;
      ras_pop     = 1'b0;
      flush_d     = flush_q;
      fault_ovf   = 1'b0;
      fault_unf   = 1'b0;
      if (!rst_n) begin
         // Counter clears itself during reset; keep every strobe quiet.
         cnt_st = 1'b0;
      end else if (state_q == ST_HALT) begin
         cnt_st  = 1'b1;
         cnt_dat = pc_in;
      end else begin
         instr_valid = !stall && !flush_q;
         unique case (kind)
            RK_STALL: begin
               cnt_st  = 1'b1;
               cnt_dat = pc_in;
            end
            RK_RET: begin
               cnt_st = 1'b1;
               if (ras_empty) begin
                  fault_unf = 1'b1;
                  cnt_dat   = pc_in;
               end else begin
                  cnt_dat = ras_top;
                  ras_pop = 1'b1;
                  flush_d = 1'b1;
               end
            end
            RK_CALL: begin
               cnt_st = 1'b1;
               if (ras_full) begin
                  fault_ovf = 1'b1;
                  cnt_dat   = pc_in;
               end else begin
                  cnt_dat  = jmp_addr;
                  ras_push = 1'b1;
                  flush_d  = 1'b1;
               end
            end
            RK_JMP: begin
               cnt_st  = 1'b1;
               cnt_dat = jmp_addr;
               flush_d = 1'b1;
            end
            default: begin
               cnt_st  = 1'b0;
               flush_d = 1'b0;
            end
         endcase
      end
   end

   assign halted  = (state_q == ST_HALT);
   assign err_ovf = err_ovf_q;
   assign err_unf = err_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pc_sequencer : directed self-checking bench; models the PC counter
// Revision        : 1.0
// ============================================================================
module tb_pc_sequencer;

   localparam int W     = 16;
   localparam int DEPTH = 8;
   localparam int DW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  pc;
   logic          stall;
   logic          jmp;
   logic          call;
   logic          ret;
   logic [W-1:0]  jmp_addr;
   logic          cnt_st;
   logic [W-1:0]  cnt_dat;
   logic          instr_valid;
   logic          halted;
   logic          err_ovf;
   logic          err_unf;
   logic [DW-1:0] ras_depth;

   int n_cmp = 0;
   int n_bad = 0;

   pc_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_in       (pc),
      .stall       (stall),
      .jmp         (jmp),
      .call        (call),
      .ret         (ret),
      .jmp_addr    (jmp_addr),
      .cnt_st      (cnt_st),
      .cnt_dat     (cnt_dat),
      .instr_valid (instr_valid),
      .halted      (halted),
      .err_ovf     (err_ovf),
      .err_unf     (err_unf),
      .ras_depth   (ras_depth)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter the sequencer steers.
   always @(posedge clk) begin
      if (!rst_n)      pc <= '0;
      else if (cnt_st) pc <= cnt_dat;
      else             pc <= pc + 16'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic s, input logic j, input logic c, input logic r,
                        input logic [W-1:0] a);
      stall = s; jmp = j; call = c; ret = r; jmp_addr = a;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
      check("rst_st",    32'(cnt_st),      32'd0);
      check("rst_dat",   32'(cnt_dat),     32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic go_to(input logic [W-1:0] tgt);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      for (int k = 0; k < 300 && pc !== tgt; k++) step();
      #1;
      check("reach_pc", 32'(pc), 32'(tgt));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();

      // Reset then free-running increment
      do_reset();
      check("rst_halted", 32'(halted),    32'd0);
      check("rst_depth",  32'(ras_depth), 32'd0);
      check("rst_errs",   32'({err_ovf, err_unf}), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check("idle_pc",    32'(pc),          32'(i));
         check("idle_st",    32'(cnt_st),      32'd0);
         check("idle_valid", 32'(instr_valid), 32'd1);
         step();
         #1;
      end

      // Jump with bubble; redirect during bubble is ignored
      do_reset();
      go_to(16'h0003);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
      check("jmp_st",    32'(cnt_st),      32'd1);
      check("jmp_dat",   32'(cnt_dat),     32'h0100);
      check("jmp_valid", 32'(instr_valid), 32'd1);
      step();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0300);
      check("bub_pc",    32'(pc),          32'h0100);
      check("bub_valid", 32'(instr_valid), 32'd0);
      check("bub_st",    32'(cnt_st),      32'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("post_pc",    32'(pc),          32'h0101);
      check("post_valid", 32'(instr_valid), 32'd1);

      // Call and matching return
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h000F);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0200);
      check("call_pc",  32'(pc),      32'h0010);
      check("call_st",  32'(cnt_st),  32'd1);
      check("call_dat", 32'(cnt_dat), 32'h0200);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("call_depth", 32'(ras_depth), 32'd1);
      go_to(16'h0205);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      check("ret_st",  32'(cnt_st),  32'd1);
      check("ret_dat", 32'(cnt_dat), 32'h0011);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("ret_pc",    32'(pc),          32'h0011);
      check("ret_depth", 32'(ras_depth),   32'd0);
      check("ret_valid", 32'(instr_valid), 32'd0);

      // Underflow: ret beats call on an empty stack, core halts
      do_reset();
      go_to(16'h0007);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0400);
      check("unf_st",   32'(cnt_st),  32'd1);
      check("unf_dat",  32'(cnt_dat), 32'h0007);
      check("unf_late", 32'(err_unf), 32'd0);
      step();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0400);
      check("unf_flag",   32'(err_unf),     32'd1);
      check("unf_halted", 32'(halted),      32'd1);
      check("unf_valid",  32'(instr_valid), 32'd0);
      check("unf_ovf",    32'(err_ovf),     32'd0);
      check("unf_hold",   32'({cnt_st, cnt_dat}), 32'h1_0007);
      check("unf_nopush", 32'(ras_depth),   32'd0);
      for (int i = 0; i < 3; i++) step();
      #1;
      check("unf_stuck", 32'(pc), 32'h0007);
      do_reset();
      check("unf_clr", 32'({halted, err_unf}), 32'd0);

      // Overflow after DEPTH nested calls
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 16'((k + 1) * 16'h0100));
         step();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
         step();
      end
      #1;
      check("ovf_depth_pre", 32'(ras_depth), 32'(DEPTH));
      check("ovf_pc_pre",    32'(pc),        32'h0801);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0900);
      check("ovf_st",  32'(cnt_st),  32'd1);
      check("ovf_dat", 32'(cnt_dat), 32'h0801);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("ovf_flag",   32'(err_ovf),   32'd1);
      check("ovf_unf",    32'(err_unf),   32'd0);
      check("ovf_halted", 32'(halted),    32'd1);
      check("ovf_depth",  32'(ras_depth), 32'(DEPTH));
      check("ovf_pc",     32'(pc),        32'h0801);

      // Stalled call is deferred; return address carries across 0x0FFF
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0FFE);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      step();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0500);
      check("stl_pc",    32'(pc),          32'h0FFF);
      check("stl_hold",  32'({cnt_st, cnt_dat}), 32'h1_0FFF);
      check("stl_valid", 32'(instr_valid), 32'd0);
      step();
      check("stl_pc2",   32'(pc),        32'h0FFF);
      check("stl_depth", 32'(ras_depth), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0500);
      check("stl_call", 32'({cnt_st, cnt_dat}), 32'h1_0500);
      check("stl_cval", 32'(instr_valid), 32'd1);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("stl_depth1", 32'(ras_depth), 32'd1);
      check("stl_bubpc",  32'(pc),        32'h0500);
      check("stl_bubhold", 32'({cnt_st, cnt_dat}), 32'h1_0500);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("stl_flushkept", 32'(instr_valid), 32'd0);
      check("stl_flushadv",  32'(cnt_st),      32'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
      check("stl_retpc",  32'(pc),          32'h0501);
      check("stl_retval", 32'(instr_valid), 32'd1);
      check("stl_retdat", 32'({cnt_st, cnt_dat}), 32'h1_1000);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      check("stl_endpc",    32'(pc),        32'h1000);
      check("stl_enddepth", 32'(ras_depth), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
